imu_angle_filter: RTL and testbench

Downstream consumer of the BNO055 IMU driver. Captures each Euler-angle sample (roll, pitch, yaw) presented with the driver's valid strobe and applies a per-axis moving average over 2^AVG_LOG2 samples. It emits filtered angles with a one-cycle valid strobe to the flight-control stage and returns a one-cycle acknowledge pulse, which drives the driver's `next_mod_active`.

---
 rtl/imu_filter_pkg.sv | 19 +
 rtl/imu_ring_buffer.sv | 43 ++++
 rtl/imu_angle_filter.sv | 165 ++++++++++++++++
 tb/tb_imu_angle_filter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/imu_filter_pkg.sv
// Shared types and constants for the IMU Euler-angle moving-average filter.
package imu_filter_pkg;

  localparam int unsigned NUM_AXES              = 3;
  localparam int unsigned BNO055_YAW_FULL_SCALE = 5760;

  localparam logic [1:0] AXIS_ROLL  = 2'd0;
  localparam logic [1:0] AXIS_PITCH = 2'd1;
  localparam logic [1:0] AXIS_YAW   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AX0,
    ST_AX1,
    ST_AX2,
    ST_OUT
  } state_t;

endpackage

// File: rtl/imu_ring_buffer.sv
// Per-axis sample history for the moving average, addressed by {axis, wr_ptr}.
// Synchronous write, combinational read; axes at or above RING_AXES read as zero.
module imu_ring_buffer
  import imu_filter_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned AVG_LOG2  = 2,
  parameter int unsigned RING_AXES = NUM_AXES
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [1:0]          axis,
  input  logic [AVG_LOG2-1:0] ptr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   rd_data_c
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned AX_W  = (RING_AXES > 1) ? $clog2(RING_AXES) : 1;

  logic [DATA_W-1:0] mem [RING_AXES][DEPTH];
  logic [AX_W-1:0]   ax_idx;
  logic              ax_ok;

  assign ax_ok  = int'(axis) < RING_AXES;
  assign ax_idx = AX_W'(axis);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int a = 0; a < RING_AXES; a++) begin
        for (int p = 0; p < DEPTH; p++) begin
          mem[a][p] <= '0;
        end
      end
    end else if (wr_en && ax_ok) begin
      mem[ax_idx][ptr] <= wr_data;
    end
  end

  assign rd_data_c = ax_ok ? mem[ax_idx][ptr] : '0;

endmodule

// File: rtl/imu_angle_filter.sv
// Per-axis moving average of BNO055 Euler angles over 2^AVG_LOG2 samples.
// Define IMU_FILTER_YAW_BYPASS_EN to pass yaw through unaveraged (avoids 0/5759 wrap).
module imu_angle_filter
  import imu_filter_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     imu_valid_strobe,
  input  logic signed [DATA_W-1:0] imu_roll,
  input  logic signed [DATA_W-1:0] imu_pitch,
  input  logic signed [DATA_W-1:0] imu_yaw,
  output logic                     imu_ack,
  output logic signed [DATA_W-1:0] filt_roll,
  output logic signed [DATA_W-1:0] filt_pitch,
  output logic signed [DATA_W-1:0] filt_yaw,
  output logic                     filt_valid_strobe,
  output logic                     overrun
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
`ifdef IMU_FILTER_YAW_BYPASS_EN
  localparam int unsigned AVG_AXES = 2;
`else
  localparam int unsigned AVG_AXES = 3;
`endif

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  state_t              state_q, state_d;
  sample_t             cap_q  [NUM_AXES];
  sample_t             cap_d  [NUM_AXES];
  sum_t                sum_q  [AVG_AXES];
  sum_t                sum_d  [AVG_AXES];
  sample_t             filt_q [NUM_AXES];
  sample_t             filt_d [NUM_AXES];
  logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    fill_q, fill_d;
  logic                ack_q, ack_d;
  logic                fvalid_q, fvalid_d;
  logic                overrun_q, overrun_d;
  logic [1:0]          axis;
  logic                ring_we;
  sample_t             ring_new;
  sample_t             ring_old;

  imu_ring_buffer #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2),
    .RING_AXES(AVG_AXES)
  ) u_ring (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .wr_en    (ring_we),
    .axis     (axis),
    .ptr      (wr_ptr_q),
    .wr_data  (ring_new),
    .rd_data_c(ring_old)
  );

  // Next-state and datapath: one axis per AX state, results published in OUT.
  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    sum_d     = sum_q;
    filt_d    = filt_q;
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    ack_d     = 1'b0;
    fvalid_d  = 1'b0;
    overrun_d = overrun_q;
    axis      = AXIS_ROLL;
    ring_we   = 1'b0;
    ring_new  = '0;

    if (imu_valid_strobe && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (imu_valid_strobe) begin
          cap_d[AXIS_ROLL]  = imu_roll;
          cap_d[AXIS_PITCH] = imu_pitch;
          cap_d[AXIS_YAW]   = imu_yaw;
          state_d           = ST_AX0;
        end
      end
      ST_AX0: begin
        axis    = AXIS_ROLL;
        state_d = ST_AX1;
      end
      ST_AX1: begin
        axis    = AXIS_PITCH;
        state_d = ST_AX2;
      end
      ST_AX2: begin
        axis     = AXIS_YAW;
        wr_ptr_d = wr_ptr_q + AVG_LOG2'(1);
        if (fill_q != CNT_W'(DEPTH)) fill_d = fill_q + CNT_W'(1);
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        ack_d = 1'b1;
        if (fill_q == CNT_W'(DEPTH)) begin
          fvalid_d = 1'b1;
          for (int i = 0; i < AVG_AXES; i++) begin
            filt_d[i] = DATA_W'(sum_q[i] >>> AVG_LOG2);
          end
`ifdef IMU_FILTER_YAW_BYPASS_EN
          filt_d[AXIS_YAW] = cap_q[AXIS_YAW];
`endif
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Swap the oldest ring sample for the new one in the running sum.
    if (state_q inside {ST_AX0, ST_AX1, ST_AX2}) begin
      ring_new = cap_q[axis];
      ring_we  = 1'b1;
      for (int i = 0; i < AVG_AXES; i++) begin
        if (axis == 2'(i)) sum_d[i] = sum_q[i] + SUM_W'(ring_new) - SUM_W'(ring_old);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      for (int i = 0; i < NUM_AXES; i++) begin
        cap_q[i]  <= '0;
        filt_q[i] <= '0;
      end
      for (int i = 0; i < AVG_AXES; i++) sum_q[i] <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      ack_q     <= 1'b0;
      fvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      sum_q     <= sum_d;
      filt_q    <= filt_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      ack_q     <= ack_d;
      fvalid_q  <= fvalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign imu_ack           = ack_q;
  assign filt_valid_strobe = fvalid_q;
  assign overrun           = overrun_q;
  assign filt_roll         = filt_q[AXIS_ROLL];
  assign filt_pitch        = filt_q[AXIS_PITCH];
  assign filt_yaw          = filt_q[AXIS_YAW];

endmodule

// File: tb/tb_imu_angle_filter.sv
// Scoreboard bench for imu_angle_filter; honours IMU_FILTER_YAW_BYPASS_EN for the yaw model.
module tb_imu_angle_filter;

  localparam int unsigned DATA_W = 16;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  logic strobe  = 1'b0;
  logic signed [DATA_W-1:0] in_r = '0, in_p = '0, in_y = '0;
  logic signed [DATA_W-1:0] f_r, f_p, f_y;
  logic ack, fvalid, ovr;

  always #5 sys_clk = ~sys_clk;

  imu_angle_filter #(.DATA_W(DATA_W), .AVG_LOG2(2)) dut (
    .sys_clk          (sys_clk),
    .reset            (reset),
    .imu_valid_strobe (strobe),
    .imu_roll         (in_r),
    .imu_pitch        (in_p),
    .imu_yaw          (in_y),
    .imu_ack          (ack),
    .filt_roll        (f_r),
    .filt_pitch       (f_p),
    .filt_yaw         (f_y),
    .filt_valid_strobe(fvalid),
    .overrun          (ovr)
  );

  typedef struct {int r; int p; int y; int c;} exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  int   ack_q[$];
  int   hr[$], hp[$], hy[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int avg4(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s >>> 2;
  endfunction

  // Drive one strobe and record the model's expected ack and (once warm) output.
  task automatic send(input int r, input int p, input int y);
    exp_t e;
    @(negedge sys_clk);
    in_r = DATA_W'(r); in_p = DATA_W'(p); in_y = DATA_W'(y);
    strobe = 1'b1;
    ack_q.push_back(cyc + 1);
    hr.push_back(r); hp.push_back(p); hy.push_back(y);
    if (hr.size() > 4) begin
      void'(hr.pop_front()); void'(hp.pop_front()); void'(hy.pop_front());
    end
    if (hr.size() == 4) begin
      e.r = avg4(hr);
      e.p = avg4(hp);
`ifdef IMU_FILTER_YAW_BYPASS_EN
      e.y = y;
`else
      e.y = avg4(hy);
`endif
      e.c = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge sys_clk);
    strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_spaced(input int r, input int p, input int y);
    send(r, p, y);
    idle(8);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    reset = 1'b1;
    exp_q.delete(); ack_q.delete();
    hr.delete(); hp.delete(); hy.delete();
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("rst_filt_roll", f_r, 0);
    check("rst_filt_pitch", f_p, 0);
    check("rst_filt_yaw", f_y, 0);
    check("rst_ack", ack, 0);
    check("rst_valid", fvalid, 0);
    check("rst_overrun", ovr, 0);
    reset = 1'b0;
  endtask

  // Output monitor: every ack / valid strobe must match a queued expectation.
  always @(negedge sys_clk) begin
    int   s;
    exp_t e;
    if (!reset) begin
      if (ack) begin
        if (ack_q.size() == 0) check("unexpected_ack", 1, 0);
        else begin
          s = ack_q.pop_front();
          check("ack_latency", cyc - s, 4);
        end
      end
      if (fvalid) begin
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("filt_roll", f_r, e.r);
          check("filt_pitch", f_p, e.p);
          check("filt_yaw", f_y, e.y);
          check("valid_latency", cyc - e.c, 4);
        end
      end
    end
  end

  initial begin
    int waited;
    do_reset();

    // Warm-up: output only on the fourth sample.
    for (int i = 0; i < 4; i++) send_spaced(160, 160, 160);
    check("warm_roll", f_r, 160);
    check("warm_yaw", f_y, 160);

    // Step response.
    do_reset();
    for (int i = 0; i < 4; i++) send_spaced(0, 0, 0);
    send_spaced(400, 0, 0);
    check("step_roll", f_r, 100);

    // Negative rounding toward minus infinity.
    do_reset();
    send_spaced(-1, 0, 0); send_spaced(-1, 0, 0);
    send_spaced(-1, 0, 0); send_spaced(-2, 0, 0);
    check("neg_round_roll", f_r, -2);
    for (int i = 0; i < 4; i++) send_spaced(-3, 0, 0);
    check("neg_const_roll", f_r, -3);

    // Overrun: strobe at k+2 dropped, strobe at k+5 accepted.
    check("overrun_before", ovr, 0);
    send(10, 20, 30);
    @(negedge sys_clk); strobe = 1'b1;
    @(negedge sys_clk); strobe = 1'b0;
    idle(1);
    send(40, 50, 60);
    idle(10);
    check("overrun_sticky", ovr, 1);

    // Reset while the sample is in AX1: no ack, warm-up restarts.
    send(50, 50, 50);
    do_reset();
    for (int i = 0; i < 3; i++) send_spaced(200, 200, 200);
    check("rewarm_held_roll", f_r, 0);
    send_spaced(200, 200, 200);
    check("rewarm_roll", f_r, 200);

    // Yaw near the 0/5759 wrap.
    do_reset();
    send_spaced(0, 0, 5750); send_spaced(0, 0, 10);
    send_spaced(0, 0, 5750); send_spaced(0, 0, 10);
`ifdef IMU_FILTER_YAW_BYPASS_EN
    check("yaw_wrap", f_y, 10);
`else
    check("yaw_wrap", f_y, (5750 + 10 + 5750 + 10) >>> 2);
`endif

    waited = 0;
    while ((exp_q.size() != 0 || ack_q.size() != 0) && waited < 50) begin
      @(negedge sys_clk);
      waited++;
    end
    check("pending_outputs", exp_q.size(), 0);
    check("pending_acks", ack_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
